// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind a UART receiver: edge-detected capture, error drop,
// first-word fall-through read, RTS hysteresis, sticky overflow and saturating error count.
module uart_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int RTS_HIGH_WATER = 12,
  parameter int RTS_LOW_WATER  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_error,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              rts,
  output logic              overflow,
  output logic [7:0]        err_count,
  input  logic              clear_flags
);

  localparam int LVL_W = ADDR_W + 1;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              rts_q, rts_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              in_valid_q, in_valid_d;
  logic              in_error_q, in_error_d;

  logic              push_req, err_evt, push_cand, push, pop, full, drop;
  logic              overflow_base;
  logic [7:0]        err_base;

  assign push_req  = in_valid & ~in_valid_q;
  assign err_evt   = in_error & ~in_error_q;
  assign push_cand = push_req & ~err_evt;
  assign full      = (level_q == LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push      = push_cand & (~full | pop);
  assign drop      = push_cand & full & ~pop;

  always_comb begin
    in_valid_d = in_valid;
    in_error_d = in_error;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    rts_d = rts_q;
    if (level_d >= LVL_W'(RTS_HIGH_WATER))
      rts_d = 1'b0;
    else if (level_d <= LVL_W'(RTS_LOW_WATER))
      rts_d = 1'b1;

    // Clear happens first, then the same-cycle event lands on the cleared value.
    overflow_base = clear_flags ? 1'b0 : overflow_q;
    overflow_d    = overflow_base | drop;

    err_base    = clear_flags ? 8'd0 : err_count_q;
    err_count_d = err_base;
    if (err_evt && (err_base != 8'hFF))
      err_count_d = err_base + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rts_q       <= 1'b1;
      overflow_q  <= 1'b0;
      err_count_q <= 8'd0;
      in_valid_q  <= 1'b1;
      in_error_q  <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rts_q       <= rts_d;
      overflow_q  <= overflow_d;
      err_count_q <= err_count_d;
      in_valid_q  <= in_valid_d;
      in_error_q  <= in_error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset)
      mem_q[wr_ptr_q] <= in_data;
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign rts       = rts_q;
  assign overflow  = overflow_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid, in_error;
  logic [7:0] out_data;
  logic       out_valid, out_ready;
  logic [4:0] level;
  logic       rts, overflow;
  logic [7:0] err_count;
  logic       clear_flags;

  int compared   = 0;
  int mismatched = 0;

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .RTS_HIGH_WATER(12), .RTS_LOW_WATER(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_error(in_error),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .level(level),
    .rts(rts), .overflow(overflow), .err_count(err_count), .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_error = 1'b0;
    out_ready = 1'b0; clear_flags = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_level", 32'(level), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd1 - 32'd1);
    check("reset_rts", 32'(rts), 32'd1);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);

    // Test 1: three bytes with out_ready=1, each visible one edge after capture.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h41 + 8'(i);
      in_valid = 1'b1;
      tick();
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_out_data", 32'(out_data), 32'h41 + 32'(i));
      in_valid = 1'b0;
      tick();
      check("t1_level_after_pop", 32'(level), 32'd0);
      $display("t1 byte %0d: out_data=%02h level=%0d", i, out_data, level);
    end
    out_ready = 1'b0;

    // Test 2: level held high for 10 cycles captures once.
    in_data = 8'h55; in_valid = 1'b1;
    repeat (10) tick();
    in_valid = 1'b0;
    tick();
    check("t2_level", 32'(level), 32'd1);
    check("t2_out_data", 32'(out_data), 32'h55);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2_drained", 32'(level), 32'd0);
    $display("t2 held-high capture: one entry 0x55");

    // Test 3: fill to 16, overflow on the 17th, drain with RTS hysteresis.
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h10 + 8'(i));
      check("t3_fill_level", 32'(level), 32'(i + 1));
      check("t3_fill_rts", 32'(rts), (i + 1 >= 12) ? 32'd0 : 32'd1);
    end
    send_byte(8'hEE);
    check("t3_full_level", 32'(level), 32'd16);
    check("t3_overflow", 32'(overflow), 32'd1);
    $display("t3 fill: level=%0d rts=%0d overflow=%0d", level, rts, overflow);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t3_drain_data", 32'(out_data), 32'h10 + 32'(i));
      tick();
      check("t3_drain_level", 32'(level), 32'(15 - i));
      check("t3_drain_rts", 32'(rts), (15 - i <= 4) ? 32'd1 : 32'd0);
    end
    out_ready = 1'b0;
    check("t3_empty_valid", 32'(out_valid), 32'd0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("t3_overflow_cleared", 32'(overflow), 32'd0);
    $display("t3 drain: level=%0d rts=%0d overflow=%0d", level, rts, overflow);

    // Test 4: error wins over a coincident byte; counter saturates.
    in_data = 8'hAA; in_valid = 1'b1; in_error = 1'b1;
    tick();
    in_valid = 1'b0; in_error = 1'b0;
    tick();
    check("t4_level", 32'(level), 32'd0);
    check("t4_err_count", 32'(err_count), 32'd1);
    for (int i = 0; i < 300; i++) begin
      in_error = 1'b1; tick();
      in_error = 1'b0; tick();
    end
    check("t4_err_saturated", 32'(err_count), 32'd255);
    clear_flags = 1'b1; in_error = 1'b1;
    tick();
    clear_flags = 1'b0; in_error = 1'b0;
    check("t4_clear_with_event", 32'(err_count), 32'd1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("t4_clear", 32'(err_count), 32'd0);
    $display("t4 errors: err_count=%0d", err_count);

    // Test 5: full FIFO, push and pop in the same cycle.
    for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i));
    check("t5_full", 32'(level), 32'd16);
    in_data = 8'h99; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t5_level_kept", 32'(level), 32'd16);
    check("t5_no_overflow", 32'(overflow), 32'd0);
    check("t5_new_head", 32'(out_data), 32'h61);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t5_drain_data", 32'(out_data), (i == 15) ? 32'h99 : 32'h61 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("t5_drained", 32'(level), 32'd0);
    check("t5_rts", 32'(rts), 32'd1);
    $display("t5 push+pop at full: tail byte 0x99 retained");

    // Test 6: reset mid-operation with in_valid held high.
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
    check("t6_level5", 32'(level), 32'd5);
    in_data = 8'h77; in_valid = 1'b1; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("t6_level", 32'(level), 32'd0);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_rts", 32'(rts), 32'd1);
    in_valid = 1'b0;
    tick();
    send_byte(8'h12);
    check("t6_after_level", 32'(level), 32'd1);
    check("t6_after_data", 32'(out_data), 32'h12);
    $display("t6 reset: level=%0d out_valid=%0d rts=%0d", level, out_valid, rts);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
